regfile_write_arbiter: RTL and testbench

Sequencer and arbiter for the 32-entry register file write port. After reset it clears every register to zero, one register per cycle. It then shares the single write port (write enable, write address, write data) between NUM_REQ requesters using round-robin arbitration with a valid/ready handshake. The write-port outputs are registered and connect directly to the register file's RegWrite, WriteReg and WriteData inputs.

---
 rtl/regfile_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register file write-port sequencer: clears NUM_REGS entries after reset, then round-robin arbitrates NUM_REQ writers.
// Latency: 1 cycle from handshake to rf_we. Backpressure: one ready per cycle, never without valid, all low while clearing.
// Option REGFILE_ZERO_GUARD_EN: accepted writes to address 0 are dropped on the port so register 0 stays zero.
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    localparam int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      init_busy,
    output logic [GNT_W-1:0]          grant_id
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [GNT_W-1:0]  LAST_REQ  = GNT_W'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [GNT_W-1:0]    ptr_q, ptr_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [GNT_W-1:0]    grant_q, grant_d;
    logic                init_busy_q, init_busy_d;

    logic                gnt_found;
    logic [GNT_W-1:0]    gnt_idx;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            grant_q     <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            grant_q     <= grant_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (cnt_q == LAST_ADDR) state_d = ST_ARB;
            ST_ARB:  state_d = ST_ARB;
            default: state_d = ST_INIT;
        endcase
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = GNT_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign xfer     = (state_q == ST_ARB) && gnt_found;
    assign sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    // Output / datapath logic
    always_comb begin
        req_ready   = '0;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        grant_d     = grant_q;
        // Stays high through the cycle that presents the last clear write
        init_busy_d = (state_q == ST_INIT);

        case (state_q)
            ST_INIT: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                cnt_d      = cnt_q + ADDR_W'(1);
            end
            ST_ARB: begin
                if (xfer) begin
                    req_ready[gnt_idx] = 1'b1;
`ifdef REGFILE_ZERO_GUARD_EN
                    rf_we_d = (sel_addr != '0);
`else
                    rf_we_d = 1'b1;
`endif
                    rf_waddr_d = sel_addr;
                    rf_wdata_d = sel_data;
                    grant_d    = gnt_idx;
                    ptr_d      = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + GNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign grant_id  = grant_q;
    assign init_busy = init_busy_q;

    a_ready_needs_valid: assert property (@(posedge clock) disable iff (reset)
        (req_ready & ~req_valid) == '0);
    a_ready_onehot0: assert property (@(posedge clock) disable iff (reset)
        $onehot0(req_ready));
    a_no_ready_in_init: assert property (@(posedge clock) disable iff (reset)
        (state_q == ST_INIT) |-> (req_ready == '0));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with NUM_REQ=2, DATA_W=32, ADDR_W=5, NUM_REGS=32.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_busy;
    logic [0:0]  grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(
        .NUM_REQ (2),
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_REGS(32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_data (req_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .init_busy(init_busy),
        .grant_id (grant_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [4:0] a, input logic [31:0] d);
        req_addr[idx*5 +: 5]   = a;
        req_data[idx*32 +: 32] = d;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        req_addr  = '0;
        req_data  = '0;

        // Reset state
        tick();
        tick();
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", init_busy, 1);
        check("rst_ready", req_ready, 0);

        // Full clear sequence with no requests
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            tick();
            check("init_we", rf_we, 1);
            check("init_waddr", rf_waddr, a);
            check("init_wdata", rf_wdata, 0);
            check("init_busy", init_busy, 1);
            check("init_ready", req_ready, 0);
        end
        tick();
        check("post_init_we", rf_we, 0);
        check("post_init_busy", init_busy, 0);

        // Single handshake from requester 0
        set_req(0, 5'd5, 32'h1234);
        req_valid = 2'b01;
        #1;
        check("single_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("single_we", rf_we, 1);
        check("single_waddr", rf_waddr, 5);
        check("single_wdata", rf_wdata, 32'h1234);
        check("single_grant", grant_id, 0);
        tick();
        check("single_idle_we", rf_we, 0);
        check("single_hold_waddr", rf_waddr, 5);
        check("single_hold_grant", grant_id, 0);

        // Both valid: pointer is 1 after the previous grant, so rotation is 1,0,1,0
        set_req(0, 5'd3, 32'hA);
        set_req(1, 5'd4, 32'hB);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int e;
            e = (k % 2 == 0) ? 1 : 0;
            #1;
            check("rr_ready", req_ready, (e == 1) ? 2'b10 : 2'b01);
            tick();
            check("rr_we", rf_we, 1);
            check("rr_waddr", rf_waddr, (e == 1) ? 4 : 3);
            check("rr_wdata", rf_wdata, (e == 1) ? 32'hB : 32'hA);
            check("rr_grant", grant_id, e);
        end
        req_valid = 2'b00;
        tick();

        // Reset mid-clear at counter 10
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 10; a++) tick();
        check("mid_waddr9", rf_waddr, 9);
        reset = 1'b1;
        tick();
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_waddr", rf_waddr, 0);
        check("mid_rst_busy", init_busy, 1);
        reset = 1'b0;

        // Requester 1 waits through the clear; first ARB cycle presents addr 31
        set_req(1, 5'd7, 32'h77);
        req_valid = 2'b10;
        for (int a = 0; a < 32; a++) begin
            tick();
            check("reinit_we", rf_we, 1);
            check("reinit_waddr", rf_waddr, a);
            check("reinit_busy", init_busy, 1);
            check("reinit_ready", req_ready, (a == 31) ? 2'b10 : 2'b00);
        end
        tick();
        req_valid = 2'b00;
        check("wait_we", rf_we, 1);
        check("wait_waddr", rf_waddr, 7);
        check("wait_wdata", rf_wdata, 32'h77);
        check("wait_grant", grant_id, 1);
        check("wait_busy", init_busy, 0);

        // Write to address 0 (pointer is back at 0)
        set_req(0, 5'd0, 32'hFFFF);
        req_valid = 2'b01;
        #1;
        check("zero_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
`ifdef REGFILE_ZERO_GUARD_EN
        check("zero_we_blocked", rf_we, 0);
        check("zero_grant", grant_id, 0);
`else
        check("zero_we", rf_we, 1);
        check("zero_waddr", rf_waddr, 0);
        check("zero_wdata", rf_wdata, 32'hFFFF);
        check("zero_grant", grant_id, 0);
`endif

        // Single persistent requester 1 is granted every cycle
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            set_req(1, 5'd9, 32'h100 + k);
            #1;
            check("pers_ready", req_ready, 2'b10);
            tick();
            check("pers_we", rf_we, 1);
            check("pers_waddr", rf_waddr, 9);
            check("pers_wdata", rf_wdata, 32'h100 + k);
            check("pers_grant", grant_id, 1);
        end
        req_valid = 2'b00;
        tick();
        check("final_idle_we", rf_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
